// File: rtl/execute_stage_pkg.sv
// Shared types and constants for the RV32I execute stage: ALU opcodes,
// forwarding selects, branch funct3 codes and the registered EX/MEM control bundle.
package execute_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_CMPU = 4'd10
  } alu_op_e;

  // Code 3 is unused by the hazard unit and falls back to the register file.
  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } exmem_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU: arithmetic, logic, shifts, set-less-than and
// an unsigned compare op that returns the difference plus the comparison flags.
module alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt_signed,
  output logic            lt_unsigned
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt       = b[SHW-1:0];
  assign lt_signed   = $signed(a) < $signed(b);
  assign lt_unsigned = a < b;
  assign zero        = (result == '0);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      ALU_CMPU: result = a - b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: operand forwarding, ALU, branch/jump resolution with a
// combinational PC redirect, and the EX/MEM pipeline register.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rd,
  input  logic            in_alu_src,
  input  logic [3:0]      in_alu_control,
  input  logic [2:0]      in_funct3,
  input  logic            in_is_branch,
  input  logic            in_is_jal,
  input  logic            in_is_jalr,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] memwb_fwd_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            exmem_valid,
  output logic [XLEN-1:0] exmem_alu_result,
  output logic [XLEN-1:0] exmem_store_data,
  output logic [4:0]      exmem_rd,
  output logic [2:0]      exmem_funct3,
  output logic            exmem_mem_read,
  output logic            exmem_mem_write,
  output logic            exmem_reg_write,
  output logic            exmem_mem_to_reg
);

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, op_b;
  logic [XLEN-1:0] alu_result, wb_result, jalr_sum;
  logic            alu_zero, alu_lt_s, alu_lt_u;
  logic            alu_flags_unused;
  logic            br_taken;
  logic [XLEN-1:0] result_q, store_q;
  exmem_t          ctrl_q, ctrl_d;

  always_comb begin
    rs1_fwd = in_rs1_data;
    case (fwd_sel_e'(fwd_a))
      FWD_EXMEM: rs1_fwd = result_q;
      FWD_MEMWB: rs1_fwd = memwb_fwd_data;
      default:   rs1_fwd = in_rs1_data;
    endcase
  end

  always_comb begin
    rs2_fwd = in_rs2_data;
    case (fwd_sel_e'(fwd_b))
      FWD_EXMEM: rs2_fwd = result_q;
      FWD_MEMWB: rs2_fwd = memwb_fwd_data;
      default:   rs2_fwd = in_rs2_data;
    endcase
  end

  assign op_b = in_alu_src ? in_imm : rs2_fwd;

  alu #(.XLEN(XLEN)) u_alu (
    .a           (rs1_fwd),
    .b           (op_b),
    .op          (alu_op_e'(in_alu_control)),
    .result      (alu_result),
    .zero        (alu_zero),
    .lt_signed   (alu_lt_s),
    .lt_unsigned (alu_lt_u)
  );

  // Branches compare rs1/rs2 directly, since operand B may be the immediate.
  assign alu_flags_unused = alu_zero & alu_lt_s & alu_lt_u;

  always_comb begin
    br_taken = 1'b0;
    case (in_funct3)
      F3_BEQ:  br_taken = (rs1_fwd == rs2_fwd);
      F3_BNE:  br_taken = (rs1_fwd != rs2_fwd);
      F3_BLT:  br_taken = ($signed(rs1_fwd) < $signed(rs2_fwd));
      F3_BGE:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      F3_BLTU: br_taken = (rs1_fwd < rs2_fwd);
      F3_BGEU: br_taken = (rs1_fwd >= rs2_fwd);
      default: br_taken = 1'b0;
    endcase
  end

  // in_valid marks a real instruction; it advances only when stall is low,
  // so gating redirect with !stall makes it fire exactly once per instruction.
  assign jalr_sum    = rs1_fwd + in_imm;
  assign redirect    = !rst && in_valid && !stall &&
                       ((in_is_branch && br_taken) || in_is_jal || in_is_jalr);
  assign redirect_pc = in_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (in_pc + in_imm);
  assign wb_result   = (in_is_jal || in_is_jalr) ? (in_pc + XLEN'(4)) : alu_result;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = in_valid;
    ctrl_d.rd         = in_rd;
    ctrl_d.funct3     = in_funct3;
    ctrl_d.mem_read   = in_mem_read   & in_valid;
    ctrl_d.mem_write  = in_mem_write  & in_valid;
    ctrl_d.reg_write  = in_reg_write  & in_valid;
    ctrl_d.mem_to_reg = in_mem_to_reg & in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ctrl_q   <= '0;
      result_q <= '0;
      store_q  <= '0;
    end else if (!stall) begin
      ctrl_q   <= ctrl_d;
      result_q <= wb_result;
      store_q  <= rs2_fwd;
    end
  end

  assign exmem_valid      = ctrl_q.valid;
  assign exmem_alu_result = result_q;
  assign exmem_store_data = store_q;
  assign exmem_rd         = ctrl_q.rd;
  assign exmem_funct3     = ctrl_q.funct3;
  assign exmem_mem_read   = ctrl_q.mem_read;
  assign exmem_mem_write  = ctrl_q.mem_write;
  assign exmem_reg_write  = ctrl_q.reg_write;
  assign exmem_mem_to_reg = ctrl_q.mem_to_reg;

endmodule
